// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared pipeline definitions: ALU opcode encoding, the packed
//               ID/EXE control bundle, the EXE-register action select and the
//               architectural zero-register index.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Register index that is hardwired to zero; writes to it are discarded.
    localparam logic [4:0] c_REG_ZERO = 5'd0;

    // ALU opcode. All sixteen codes are named so any 4-bit value on the
    // decode bus maps to a legal enumerator.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_LUI    = 4'd10,
        ALU_PASS_B = 4'd11,
        ALU_RSV_C  = 4'd12,
        ALU_RSV_D  = 4'd13,
        ALU_RSV_E  = 4'd14,
        ALU_RSV_F  = 4'd15
    } alu_op_e;

    // Everything that crosses ID/EXE except the XLEN-wide data fields.
    typedef struct packed {
        logic       valid;
        alu_op_e    alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       uses_rs1;
        logic       uses_rs2;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rd_addr;
    } id_exe_ctrl_t;

    // A bubble is the all-zero bundle: not valid, no side effects, ALU_ADD.
    localparam id_exe_ctrl_t c_CTRL_BUBBLE = '0;

    // What the EXE register does on the coming edge.
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_FLUSH  = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_LOAD   = 2'd3
    } exe_action_e;

    // Strip architectural side effects from an instruction that is not valid.
    // RegWrite is also dropped for rd = x0 so the forwarding unit never sees
    // a producer for the zero register.
    function automatic id_exe_ctrl_t gate_ctrl(input id_exe_ctrl_t c);
        id_exe_ctrl_t g;
        g           = c;
        g.reg_write = c.reg_write & c.valid & (c.rd_addr != c_REG_ZERO);
        g.mem_read  = c.mem_read  & c.valid;
        g.mem_write = c.mem_write & c.valid;
        g.branch    = c.branch    & c.valid;
        return g;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detector. Flags an ID-stage
//               instruction that reads the destination of a load currently
//               in EXE. Suppressed while EXE redirects the fetch stream, since
//               the ID instruction is about to be squashed anyway.
// Ports       : i_id_valid / i_id_rs*_addr / i_id_uses_rs* - ID source info
//               i_exe_valid / i_exe_mem_read / i_exe_rd_addr - EXE producer
//               i_flush        - branch/jump taken in EXE
//               o_hazard_stall - freeze PC and IF/ID, bubble into EXE
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import cpu_pkg::*;
(
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1_addr,
    input  logic [4:0] i_id_rs2_addr,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic       i_exe_valid,
    input  logic       i_exe_mem_read,
    input  logic [4:0] i_exe_rd_addr,
    input  logic       i_flush,
    output logic       o_hazard_stall
);

    logic w_exe_is_load;
    logic w_rs1_match;
    logic w_rs2_match;

    // A load into x0 produces nothing that anyone can depend on.
    assign w_exe_is_load = i_exe_valid & i_exe_mem_read & (i_exe_rd_addr != c_REG_ZERO);

    // Only count a match when the operand is really read; unused source
    // fields often carry leftover immediate bits.
    assign w_rs1_match = i_id_uses_rs1 & (i_id_rs1_addr == i_exe_rd_addr);
    assign w_rs2_match = i_id_uses_rs2 & (i_id_rs2_addr == i_exe_rd_addr);

    assign o_hazard_stall = ~i_flush & i_id_valid & w_exe_is_load & (w_rs1_match | w_rs2_match);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/id_exe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_reg
// Description : ID/EXE pipeline register with load-use bubble insertion,
//               branch flush, global memory-stall hold and two saturating
//               performance counters (load-use bubbles, flushes).
// Ports       : clk, rst (async, active low)
//               ID_*              - decoded instruction from the ID stage
//               EXE_branch_taken  - flush request from EXE
//               mem_stall         - global freeze from data memory
//               cnt_clr           - synchronous counter clear
//               EXE_*             - registered instruction for the EXE stage
//               hazard_stall      - combinational load-use stall to PC, IF/ID
//               bubble_cnt        - edges that loaded a load-use bubble
//               flush_cnt         - edges that loaded a flush bubble
// Revision    : 1.0 - initial release
// ============================================================================
module id_exe_reg
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             ID_valid,
    input  logic [XLEN-1:0]  ID_pc,
    input  logic [XLEN-1:0]  ID_rs1_data,
    input  logic [XLEN-1:0]  ID_rs2_data,
    input  logic [XLEN-1:0]  ID_imm,
    input  logic [4:0]       ID_rs1_addr,
    input  logic [4:0]       ID_rs2_addr,
    input  logic [4:0]       ID_rd_addr,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic [3:0]       ID_ALUOp,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             ID_MemWrite,
    input  logic             ID_MemtoReg,
    input  logic             ID_ALUSrc,
    input  logic             ID_Branch,

    input  logic             EXE_branch_taken,
    input  logic             mem_stall,
    input  logic             cnt_clr,

    output logic             EXE_valid,
    output logic [XLEN-1:0]  EXE_pc,
    output logic [XLEN-1:0]  EXE_rs1_data,
    output logic [XLEN-1:0]  EXE_rs2_data,
    output logic [XLEN-1:0]  EXE_imm,
    output logic [4:0]       EXE_rs1_addr,
    output logic [4:0]       EXE_rs2_addr,
    output logic [4:0]       EXE_rd_addr,
    output logic             EXE_uses_rs1,
    output logic             EXE_uses_rs2,
    output logic [3:0]       EXE_ALUOp,
    output logic             EXE_RegWrite,
    output logic             EXE_MemRead,
    output logic             EXE_MemWrite,
    output logic             EXE_MemtoReg,
    output logic             EXE_ALUSrc,
    output logic             EXE_Branch,

    output logic             hazard_stall,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    id_exe_ctrl_t     r_ctrl;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    id_exe_ctrl_t     w_id_ctrl;
    id_exe_ctrl_t     w_load_ctrl;
    logic             w_hazard;
    exe_action_e      w_action;

    // ------------------------------------------------------------------
    // Hazard detection against the instruction currently held in EXE
    // ------------------------------------------------------------------
    load_use_detect u_load_use_detect (
        .i_id_valid     (ID_valid),
        .i_id_rs1_addr  (ID_rs1_addr),
        .i_id_rs2_addr  (ID_rs2_addr),
        .i_id_uses_rs1  (ID_uses_rs1),
        .i_id_uses_rs2  (ID_uses_rs2),
        .i_exe_valid    (r_ctrl.valid),
        .i_exe_mem_read (r_ctrl.mem_read),
        .i_exe_rd_addr  (r_ctrl.rd_addr),
        .i_flush        (EXE_branch_taken),
        .o_hazard_stall (w_hazard)
    );

    assign hazard_stall = w_hazard;

    // ------------------------------------------------------------------
    // Bundle the ID control fields and gate their side effects
    // ------------------------------------------------------------------
    always_comb begin
        w_id_ctrl            = c_CTRL_BUBBLE;
        w_id_ctrl.valid      = ID_valid;
        w_id_ctrl.alu_op     = alu_op_e'(ID_ALUOp);
        w_id_ctrl.reg_write  = ID_RegWrite;
        w_id_ctrl.mem_read   = ID_MemRead;
        w_id_ctrl.mem_write  = ID_MemWrite;
        w_id_ctrl.mem_to_reg = ID_MemtoReg;
        w_id_ctrl.alu_src    = ID_ALUSrc;
        w_id_ctrl.branch     = ID_Branch;
        w_id_ctrl.uses_rs1   = ID_uses_rs1;
        w_id_ctrl.uses_rs2   = ID_uses_rs2;
        w_id_ctrl.rs1_addr   = ID_rs1_addr;
        w_id_ctrl.rs2_addr   = ID_rs2_addr;
        w_id_ctrl.rd_addr    = ID_rd_addr;
    end

    assign w_load_ctrl = gate_ctrl(w_id_ctrl);

    // ------------------------------------------------------------------
    // One action per edge. The memory stall outranks everything: a pending
    // flush or hazard is still being asserted by its source and will take
    // effect on the first edge after the stall releases.
    // ------------------------------------------------------------------
    always_comb begin
        w_action = ACT_LOAD;
        if (mem_stall) begin
            w_action = ACT_HOLD;
        end else if (EXE_branch_taken) begin
            w_action = ACT_FLUSH;
        end else if (w_hazard) begin
            w_action = ACT_BUBBLE;
        end
    end

    // ------------------------------------------------------------------
    // EXE register. Reset drops any held instruction without replay.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl     <= c_CTRL_BUBBLE;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
        end else begin
            case (w_action)
                ACT_LOAD: begin
                    r_ctrl     <= w_load_ctrl;
                    r_pc       <= ID_pc;
                    r_rs1_data <= ID_rs1_data;
                    r_rs2_data <= ID_rs2_data;
                    r_imm      <= ID_imm;
                end
                ACT_FLUSH, ACT_BUBBLE: begin
                    r_ctrl     <= c_CTRL_BUBBLE;
                    r_pc       <= '0;
                    r_rs1_data <= '0;
                    r_rs2_data <= '0;
                    r_imm      <= '0;
                end
                ACT_HOLD: begin
                    r_ctrl     <= r_ctrl;
                    r_pc       <= r_pc;
                    r_rs1_data <= r_rs1_data;
                    r_rs2_data <= r_rs2_data;
                    r_imm      <= r_imm;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters. Clear beats increment; a held edge
    // never counts because its action is ACT_HOLD.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (cnt_clr) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if ((w_action == ACT_BUBBLE) && (r_bubble_cnt != c_CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
            end
            if ((w_action == ACT_FLUSH) && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign EXE_valid    = r_ctrl.valid;
    assign EXE_pc       = r_pc;
    assign EXE_rs1_data = r_rs1_data;
    assign EXE_rs2_data = r_rs2_data;
    assign EXE_imm      = r_imm;
    assign EXE_rs1_addr = r_ctrl.rs1_addr;
    assign EXE_rs2_addr = r_ctrl.rs2_addr;
    assign EXE_rd_addr  = r_ctrl.rd_addr;
    assign EXE_uses_rs1 = r_ctrl.uses_rs1;
    assign EXE_uses_rs2 = r_ctrl.uses_rs2;
    assign EXE_ALUOp    = r_ctrl.alu_op;
    assign EXE_RegWrite = r_ctrl.reg_write;
    assign EXE_MemRead  = r_ctrl.mem_read;
    assign EXE_MemWrite = r_ctrl.mem_write;
    assign EXE_MemtoReg = r_ctrl.mem_to_reg;
    assign EXE_ALUSrc   = r_ctrl.alu_src;
    assign EXE_Branch   = r_ctrl.branch;

    assign bubble_cnt   = r_bubble_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule : id_exe_reg
`default_nettype wire

// File: tb/tb_id_exe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_exe_reg
// Description : Scoreboard bench for id_exe_reg. The driver applies one
//               stimulus per cycle, advances a behavioural model of the
//               stage and queues the expected view; a negedge monitor pops
//               and compares. Counters are narrowed so saturation is reached
//               within a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_exe_reg;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            uses1;
        logic            uses2;
        logic [3:0]      aluop;
        logic            rw;
        logic            mr;
        logic            mw;
        logic            m2r;
        logic            asrc;
        logic            br;
    } exe_t;

    typedef struct packed {
        exe_t id;
        logic br;
        logic ms;
        logic clr;
    } stim_t;

    typedef struct {
        exe_t exe;
        int   bubble;
        int   flush;
        logic hz;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    stim_t cur;

    logic             EXE_valid;
    logic [XLEN-1:0]  EXE_pc, EXE_rs1_data, EXE_rs2_data, EXE_imm;
    logic [4:0]       EXE_rs1_addr, EXE_rs2_addr, EXE_rd_addr;
    logic             EXE_uses_rs1, EXE_uses_rs2;
    logic [3:0]       EXE_ALUOp;
    logic             EXE_RegWrite, EXE_MemRead, EXE_MemWrite;
    logic             EXE_MemtoReg, EXE_ALUSrc, EXE_Branch;
    logic             hazard_stall;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    exe_t m_exe;
    int   m_bubble;
    int   m_flush;
    exp_t q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    id_exe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .ID_valid         (cur.id.valid),
        .ID_pc            (cur.id.pc),
        .ID_rs1_data      (cur.id.rs1_data),
        .ID_rs2_data      (cur.id.rs2_data),
        .ID_imm           (cur.id.imm),
        .ID_rs1_addr      (cur.id.rs1),
        .ID_rs2_addr      (cur.id.rs2),
        .ID_rd_addr       (cur.id.rd),
        .ID_uses_rs1      (cur.id.uses1),
        .ID_uses_rs2      (cur.id.uses2),
        .ID_ALUOp         (cur.id.aluop),
        .ID_RegWrite      (cur.id.rw),
        .ID_MemRead       (cur.id.mr),
        .ID_MemWrite      (cur.id.mw),
        .ID_MemtoReg      (cur.id.m2r),
        .ID_ALUSrc        (cur.id.asrc),
        .ID_Branch        (cur.id.br),
        .EXE_branch_taken (cur.br),
        .mem_stall        (cur.ms),
        .cnt_clr          (cur.clr),
        .EXE_valid        (EXE_valid),
        .EXE_pc           (EXE_pc),
        .EXE_rs1_data     (EXE_rs1_data),
        .EXE_rs2_data     (EXE_rs2_data),
        .EXE_imm          (EXE_imm),
        .EXE_rs1_addr     (EXE_rs1_addr),
        .EXE_rs2_addr     (EXE_rs2_addr),
        .EXE_rd_addr      (EXE_rd_addr),
        .EXE_uses_rs1     (EXE_uses_rs1),
        .EXE_uses_rs2     (EXE_uses_rs2),
        .EXE_ALUOp        (EXE_ALUOp),
        .EXE_RegWrite     (EXE_RegWrite),
        .EXE_MemRead      (EXE_MemRead),
        .EXE_MemWrite     (EXE_MemWrite),
        .EXE_MemtoReg     (EXE_MemtoReg),
        .EXE_ALUSrc       (EXE_ALUSrc),
        .EXE_Branch       (EXE_Branch),
        .hazard_stall     (hazard_stall),
        .bubble_cnt       (bubble_cnt),
        .flush_cnt        (flush_cnt)
    );

    // ---------------------------------------------------------------- checks
    function automatic void check(input string name, input logic [255:0] act,
                                  input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic exe_t act_exe();
        return {EXE_valid, EXE_pc, EXE_rs1_data, EXE_rs2_data, EXE_imm,
                EXE_rs1_addr, EXE_rs2_addr, EXE_rd_addr, EXE_uses_rs1, EXE_uses_rs2,
                EXE_ALUOp, EXE_RegWrite, EXE_MemRead, EXE_MemWrite,
                EXE_MemtoReg, EXE_ALUSrc, EXE_Branch};
    endfunction

    // ----------------------------------------------------------------- model
    function automatic int sat(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // Would the ID instruction read the value a load in EXE has not yet fetched?
    function automatic logic model_hazard(input stim_t s);
        if (s.br) return 1'b0;
        if (!(s.id.valid && m_exe.valid && m_exe.mr && m_exe.rd != 5'd0)) return 1'b0;
        return (s.id.uses1 && s.id.rs1 == m_exe.rd) || (s.id.uses2 && s.id.rs2 == m_exe.rd);
    endfunction

    function automatic exe_t issue(input exe_t id);
        exe_t e;
        e    = id;
        e.rw = id.rw && id.valid && (id.rd != 5'd0);
        e.mr = id.mr && id.valid;
        e.mw = id.mw && id.valid;
        e.br = id.br && id.valid;
        return e;
    endfunction

    function automatic void model_step(input stim_t s);
        logic hz;
        hz = model_hazard(s);
        if (!s.ms) begin
            if (s.br) begin
                m_exe   = '0;
                m_flush = sat(m_flush);
            end else if (hz) begin
                m_exe    = '0;
                m_bubble = sat(m_bubble);
            end else begin
                m_exe = issue(s.id);
            end
        end
        if (s.clr) begin
            m_bubble = 0;
            m_flush  = 0;
        end
    endfunction

    // ------------------------------------------------------------- stimulus
    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t ld(input logic [4:0] rd);
        stim_t s;
        s          = '0;
        s.id.valid = 1'b1;
        s.id.pc    = 32'h0000_0100;
        s.id.imm   = 32'h0000_0010;
        s.id.rs1   = 5'd1;
        s.id.uses1 = 1'b1;
        s.id.rd    = rd;
        s.id.rw    = 1'b1;
        s.id.mr    = 1'b1;
        s.id.m2r   = 1'b1;
        s.id.asrc  = 1'b1;
        return s;
    endfunction

    function automatic stim_t add(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd);
        stim_t s;
        s             = '0;
        s.id.valid    = 1'b1;
        s.id.pc       = 32'h0000_0104;
        s.id.rs1_data = 32'h1111_1111;
        s.id.rs2_data = 32'h2222_2222;
        s.id.rs1      = rs1;
        s.id.rs2      = rs2;
        s.id.rd       = rd;
        s.id.uses1    = 1'b1;
        s.id.uses2    = 1'b1;
        s.id.rw       = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.id.valid    = ($urandom_range(0, 7) != 0);
        s.id.pc       = $urandom;
        s.id.rs1_data = $urandom;
        s.id.rs2_data = $urandom;
        s.id.imm      = $urandom;
        s.id.rs1      = 5'($urandom_range(0, 3));
        s.id.rs2      = 5'($urandom_range(0, 3));
        s.id.rd       = 5'($urandom_range(0, 3));
        s.id.uses1    = 1'($urandom_range(0, 1));
        s.id.uses2    = 1'($urandom_range(0, 1));
        s.id.aluop    = 4'($urandom_range(0, 15));
        s.id.rw       = 1'($urandom_range(0, 1));
        s.id.mr       = 1'($urandom_range(0, 1));
        s.id.mw       = 1'($urandom_range(0, 1));
        s.id.m2r      = 1'($urandom_range(0, 1));
        s.id.asrc     = 1'($urandom_range(0, 1));
        s.id.br       = 1'($urandom_range(0, 1));
        s.br          = ($urandom_range(0, 3) == 0);
        s.ms          = ($urandom_range(0, 3) == 0);
        s.clr         = ($urandom_range(0, 63) == 0);
        return s;
    endfunction

    // Step the model over the coming edge with the inputs already applied,
    // then apply the next inputs and queue what the DUT should now present.
    task automatic cycle(input stim_t s);
        exp_t e;
        @(posedge clk);
        model_step(cur);
        #1;
        cur      = s;
        e.exe    = m_exe;
        e.bubble = m_bubble;
        e.flush  = m_flush;
        e.hz     = model_hazard(s);
        q.push_back(e);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check({tag, "_exe_fields"}, 256'(act_exe()), 256'(0));
        check({tag, "_hazard"},     256'(hazard_stall), 256'(0));
        check({tag, "_bubble_cnt"}, 256'(bubble_cnt), 256'(0));
        check({tag, "_flush_cnt"},  256'(flush_cnt), 256'(0));
        m_exe    = '0;
        m_bubble = 0;
        m_flush  = 0;
        #1;
        rst = 1'b1;
    endtask

    // --------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("exe_fields",   256'(act_exe()),    256'(mon_e.exe));
            check("hazard_stall", 256'(hazard_stall), 256'(mon_e.hz));
            check("bubble_cnt",   256'(bubble_cnt),   256'(mon_e.bubble));
            check("flush_cnt",    256'(flush_cnt),    256'(mon_e.flush));
        end
    end

    // ---------------------------------------------------------------- driver
    initial begin
        stim_t s;
        rst      = 1'b0;
        cur      = nop();
        m_exe    = '0;
        m_bubble = 0;
        m_flush  = 0;
        #2;
        check("reset_exe_fields", 256'(act_exe()),    256'(0));
        check("reset_hazard",     256'(hazard_stall), 256'(0));
        check("reset_bubble_cnt", 256'(bubble_cnt),   256'(0));
        check("reset_flush_cnt",  256'(flush_cnt),    256'(0));
        #10;
        rst = 1'b1;

        // Load-use on x5: stall, one bubble, then the add issues.
        cycle(ld(5'd5));
        cycle(add(5'd5, 5'd6, 5'd7));
        cycle(add(5'd5, 5'd6, 5'd7));
        cycle(nop());

        // Load into x0 never stalls; an add writing x0 must not RegWrite.
        cycle(ld(5'd0));
        cycle(add(5'd5, 5'd6, 5'd0));
        cycle(nop());

        // Hazard together with a taken branch: flush wins, no stall.
        cycle(ld(5'd5));
        s    = add(5'd5, 5'd6, 5'd7);
        s.br = 1'b1;
        cycle(s);
        cycle(nop());

        // Memory stall for three edges with a hazard pending.
        cycle(ld(5'd5));
        s    = add(5'd6, 5'd5, 5'd7);
        s.ms = 1'b1;
        repeat (3) cycle(s);
        s.ms = 1'b0;
        cycle(s);
        cycle(s);
        cycle(nop());

        // Async reset while a valid instruction sits in EXE.
        cycle(ld(5'd5));
        reset_pulse("rst_async");
        cycle(nop());

        // Async reset in the middle of a memory stall: held load is dropped.
        cycle(ld(5'd5));
        s    = add(5'd5, 5'd6, 5'd7);
        s.ms = 1'b1;
        cycle(s);
        reset_pulse("rst_midstall");
        s.ms = 1'b0;
        cycle(s);
        cycle(nop());

        // Saturation: drive the bubble counter to max-1, then three more.
        s     = nop();
        s.clr = 1'b1;
        cycle(s);
        repeat (CNT_MAX - 1) begin
            cycle(ld(5'd5));
            cycle(add(5'd5, 5'd6, 5'd7));
        end
        repeat (3) begin
            cycle(ld(5'd5));
            cycle(add(5'd5, 5'd6, 5'd7));
        end
        cycle(ld(5'd5));
        s     = add(5'd5, 5'd6, 5'd7);
        s.clr = 1'b1;
        cycle(s);
        cycle(nop());

        // Randomised traffic.
        repeat (400) cycle(rand_stim());
        cycle(nop());

        @(negedge clk);
        #1;
        check("scoreboard_drain", 256'(q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_id_exe_reg
`default_nettype wire

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 Parameter XLEN, default 32: datapath width of PC, operand and immediate fields.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ID_valid  input  1  ID stage holds a real instruction.
REQ-006 ID_pc, ID_rs1_data, ID_rs2_data, ID_imm  input  XLEN each  decoded PC, operands and immediate.
REQ-007 ID_rs1_addr, ID_rs2_addr, ID_rd_addr  input  5 each  register indices.
REQ-008 ID_uses_rs1, ID_uses_rs2  input  1 each  instruction actually reads rs1/rs2.
REQ-009 ID_ALUOp  input  4  ALU opcode; ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Branch  input  1 each  control bits.
REQ-010 EXE_branch_taken  input  1  branch/jump resolved taken in EXE; flush request.
REQ-011 mem_stall  input  1  global freeze from the data-memory wait.
REQ-012 cnt_clr  input  1  synchronous clear of both counters.
REQ-013 EXE_* outputs  output  same widths as the ID_* inputs  registered copies, including EXE_valid; these EXE_RegWrite/EXE_rd_addr drive the forwarding unit.
REQ-014 hazard_stall  output  1  combinational; freezes PC and the IF/ID register.
REQ-015 bubble_cnt, flush_cnt  output  CNT_W each  load-use bubble and flush counters.

Function
REQ-016 Load-use hazard: hazard_stall = ID_valid & EXE_valid & EXE_MemRead & (EXE_rd_addr != 0) & ((ID_uses_rs1 & ID_rs1_addr == EXE_rd_addr) | (ID_uses_rs2 & ID_rs2_addr == EXE_rd_addr)).
REQ-017 hazard_stall is forced to 0 while EXE_branch_taken is 1, since the ID instruction is squashed.
REQ-018 Each rising edge, the EXE register takes exactly one action, in priority order: mem_stall=1 -> hold all fields; else EXE_branch_taken=1 -> load bubble; else hazard_stall=1 -> load bubble; else load ID fields.
REQ-019 Bubble: EXE_valid and all control outputs 0; EXE_ALUOp 0; all address and data fields 0.
REQ-020 On load, EXE_RegWrite = ID_RegWrite & ID_valid & (ID_rd_addr != 0); EXE_MemWrite, EXE_MemRead and EXE_Branch are likewise gated by ID_valid.
REQ-021 Load-to-output latency is 1 cycle; a hazard inserts exactly 1 bubble, after which the dependency is served by MEM-stage forwarding.
REQ-022 bubble_cnt increments on each edge that loads a bubble because of hazard_stall; flush_cnt increments on each edge that loads a bubble because of EXE_branch_taken; neither counts while mem_stall=1.
REQ-023 Counters saturate at all-ones and do not wrap.
REQ-024 cnt_clr=1 zeroes both counters on the next edge and takes priority over an increment in the same cycle.
REQ-025 mem_stall concurrent with a flush or hazard: hold wins; the flush or hazard remains asserted by its source and acts on the first edge after mem_stall drops.

Reset
REQ-026 rst=0 immediately clears the EXE register to the bubble state of REQ-019 and zeroes both counters, independent of clk.
REQ-027 While rst=0, hazard_stall is 0 because EXE_valid=0; after deassertion, the first edge loads ID normally.
REQ-028 Reset asserted mid-stall discards the held instruction; no replay is performed.

Structure
REQ-029 The ALUOp encoding and a packed ID/EXE control-bundle type live in the shared package cpu_pkg, together with the constant for register index 0.
REQ-030 Hazard detection (REQ-016/017) is one combinational sub-module, load_use_detect; the register and counters stay in id_exe_reg.

Verification
REQ-031 Load x5 in EXE (MemRead=1, rd=5), ID add with rs1=5, uses_rs1=1 -> hazard_stall=1, next EXE_valid=0, bubble_cnt 0->1; following edge loads the add.
REQ-032 Same as REQ-031 but rd=0 -> hazard_stall=0, add loads directly; ID rd=0 with RegWrite=1 -> EXE_RegWrite=0.
REQ-033 Hazard and EXE_branch_taken in the same cycle -> hazard_stall=0, bubble loaded, flush_cnt+1, bubble_cnt unchanged.
REQ-034 mem_stall=1 for 3 cycles with hazard present -> EXE fields constant for 3 edges, counters unchanged; bubble on the 4th edge.
REQ-035 Preset bubble_cnt to 0xFFFE, drive 3 hazards -> 0xFFFF held; cnt_clr together with a hazard -> 0.
REQ-036 rst pulsed low between clock edges while EXE_valid=1 -> outputs zero immediately, before the next clk edge.
